// File: rtl/fb_pkg.sv
// Shared constants and types for the double-buffered frame buffer controller.
package fb_pkg;
    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 180;
    localparam int FB_DEPTH  = FB_WIDTH * FB_HEIGHT;

    localparam logic [15:0] CLEAR_COLOR = 16'h0000;

    typedef enum logic [1:0] {CLEAR, RENDER, WAIT_SWAP} fb_state_t;

    typedef logic [15:0] rgb565_t;
endpackage

// File: rtl/fb_clear_engine.sv
// Clear address sequencer: walks 0..DEPTH-1 one word per cycle while busy.
// Comes out of reset already busy so the first frame is cleared without a start.
module fb_clear_engine #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        last,
    output logic [15:0] addr,
    output logic        en
);
    localparam logic [15:0] LAST_ADDR = 16'(DEPTH - 1);

    logic        busy;
    logic [15:0] cnt;

    // Final address is being issued this cycle.
    assign last = busy && (cnt == LAST_ADDR);

    // Counter and registered write strobe/address.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b1;
            cnt  <= '0;
            en   <= 1'b0;
            addr <= '0;
        end else begin
            en <= busy;
            if (busy) addr <= cnt;
            if (start) begin
                busy <= 1'b1;
                cnt  <= '0;
            end else if (busy) begin
                if (last) busy <= 1'b0;
                else      cnt  <= cnt + 16'd1;
            end
        end
    end
endmodule

// File: rtl/fb_swap_ctrl.sv
// Double-buffer controller: clears the back buffer, lets the renderer fill it,
// and swaps buffers only on the new-frame pulse. Owns the shared BRAM write port.
module fb_swap_ctrl #(
    parameter int          FB_WIDTH    = fb_pkg::FB_WIDTH,
    parameter int          FB_HEIGHT   = fb_pkg::FB_HEIGHT,
    parameter logic [15:0] CLEAR_COLOR = fb_pkg::CLEAR_COLOR
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        nf_in,
    input  logic        frame_done_in,
    input  logic        px_valid_in,
    input  logic [15:0] px_addr_in,
    input  logic [15:0] px_color_in,
    output logic        px_ready_out,
    output logic [15:0] wr_addr_out,
    output logic [15:0] wr_data_out,
    output logic [1:0]  wr_en_out,
    output logic        display_sel_out,
    output logic        frame_start_out,
    output logic [7:0]  overrun_count_out
);
    import fb_pkg::*;

    localparam int          DEPTH   = FB_WIDTH * FB_HEIGHT;
    localparam logic [16:0] DEPTH17 = 17'(DEPTH);

    fb_state_t   state;
    logic        clr_start, clr_last, clr_en;
    logic [15:0] clr_addr;
    logic        px_en;
    logic [15:0] px_addr;
    rgb565_t     px_data;
    logic        accept, in_range;

    // The clear restarts the moment the swap is taken.
    assign clr_start = (state == WAIT_SWAP) && nf_in;
    assign accept    = px_ready_out && px_valid_in;
    assign in_range  = {1'b0, px_addr_in} < DEPTH17;

    fb_clear_engine #(.DEPTH(DEPTH)) u_clear (
        .clk   (clk_in),
        .rst   (rst_in),
        .start (clr_start),
        .last  (clr_last),
        .addr  (clr_addr),
        .en    (clr_en)
    );

    // Sequencer FSM, pixel write register and overrun counter.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state             <= CLEAR;
            display_sel_out   <= 1'b0;
            px_ready_out      <= 1'b0;
            frame_start_out   <= 1'b0;
            overrun_count_out <= '0;
            px_en             <= 1'b0;
            px_addr           <= '0;
            px_data           <= '0;
        end else begin
            frame_start_out <= 1'b0;
            px_en           <= 1'b0;
            // Out-of-range pixels are consumed but never written.
            if (accept) begin
                px_en   <= in_range;
                px_addr <= px_addr_in;
                px_data <= px_color_in;
            end
            // A new frame arriving before the back buffer is ready is a missed swap.
            if (nf_in && state != WAIT_SWAP && overrun_count_out != 8'hFF)
                overrun_count_out <= overrun_count_out + 8'd1;
            case (state)
                CLEAR: if (clr_last) begin
                    state           <= RENDER;
                    px_ready_out    <= 1'b1;
                    frame_start_out <= 1'b1;
                end
                RENDER: if (frame_done_in) begin
                    state        <= WAIT_SWAP;
                    px_ready_out <= 1'b0;
                end
                WAIT_SWAP: if (nf_in) begin
                    display_sel_out <= ~display_sel_out;
                    state           <= CLEAR;
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // Clear and pixel writes never overlap in time, so the port is a simple mux
    // of the two registered paths, always aimed at the back buffer.
    always_comb begin
        wr_en_out   = 2'b00;
        wr_addr_out = clr_en ? clr_addr : px_addr;
        wr_data_out = clr_en ? CLEAR_COLOR : px_data;
        if (clr_en || px_en)
            wr_en_out = display_sel_out ? 2'b01 : 2'b10;
    end
endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Directed bench for fb_swap_ctrl with a 4x4 (16-word) frame buffer.
module tb_fb_swap_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        nf = 1'b0;
    logic        frame_done = 1'b0;
    logic        px_valid = 1'b0;
    logic [15:0] px_addr = '0;
    logic [15:0] px_color = '0;
    logic        px_ready;
    logic [15:0] wr_addr, wr_data;
    logic [1:0]  wr_en;
    logic        display_sel, frame_start;
    logic [7:0]  overrun;

    int checks = 0;
    int errors = 0;

    fb_swap_ctrl #(.FB_WIDTH(4), .FB_HEIGHT(4), .CLEAR_COLOR(16'h0000)) dut (
        .clk_in            (clk),
        .rst_in            (rst),
        .nf_in             (nf),
        .frame_done_in     (frame_done),
        .px_valid_in       (px_valid),
        .px_addr_in        (px_addr),
        .px_color_in       (px_color),
        .px_ready_out      (px_ready),
        .wr_addr_out       (wr_addr),
        .wr_data_out       (wr_data),
        .wr_en_out         (wr_en),
        .display_sel_out   (display_sel),
        .frame_start_out   (frame_start),
        .overrun_count_out (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs changed 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " wr_en"}, 32'(wr_en), 32'h0);
        chk({tag, " wr_addr"}, 32'(wr_addr), 32'h0);
        chk({tag, " wr_data"}, 32'(wr_data), 32'h0);
        chk({tag, " ready"}, 32'(px_ready), 32'h0);
        chk({tag, " fstart"}, 32'(frame_start), 32'h0);
        chk({tag, " overrun"}, 32'(overrun), 32'h0);
        chk({tag, " sel"}, 32'(display_sel), 32'h0);
    endtask

    initial begin
        step();
        step();
        chk_reset("reset");
        rst = 1'b0;

        // First clear of buffer 1; frame_done and two nf pulses land inside it.
        for (int i = 0; i < 16; i++) begin
            frame_done = (i == 3);
            nf         = (i == 5 || i == 8);
            step();
            chk("clr wr_en", 32'(wr_en), 32'h2);
            chk("clr addr", 32'(wr_addr), 32'(i));
            chk("clr data", 32'(wr_data), 32'h0);
            if (i < 15) chk("clr ready", 32'(px_ready), 32'h0);
        end
        frame_done = 1'b0;
        nf         = 1'b0;
        chk("render fstart", 32'(frame_start), 32'h1);
        chk("render ready", 32'(px_ready), 32'h1);
        step();
        chk("clear ended", 32'(wr_en), 32'h0);
        chk("fstart pulse", 32'(frame_start), 32'h0);
        chk("overrun clear", 32'(overrun), 32'h2);

        // Pixel writes in RENDER.
        px_valid = 1'b1; px_addr = 16'd5; px_color = 16'hF800;
        step();
        chk("px5 wr_en", 32'(wr_en), 32'h2);
        chk("px5 addr", 32'(wr_addr), 32'h5);
        chk("px5 data", 32'(wr_data), 32'hF800);
        px_addr = 16'd16; px_color = 16'h1234;
        step();
        chk("px16 wr_en", 32'(wr_en), 32'h0);
        chk("px16 ready", 32'(px_ready), 32'h1);
        px_valid = 1'b0; nf = 1'b1;
        step();
        nf = 1'b0;
        chk("overrun 3", 32'(overrun), 32'h3);

        // Last pixel alongside frame_done is still written.
        px_valid = 1'b1; px_addr = 16'd3; px_color = 16'h001F; frame_done = 1'b1;
        step();
        frame_done = 1'b0;
        px_addr = 16'd2;
        chk("px3 wr_en", 32'(wr_en), 32'h2);
        chk("px3 addr", 32'(wr_addr), 32'h3);
        chk("px3 data", 32'(wr_data), 32'h001F);
        chk("wait ready", 32'(px_ready), 32'h0);
        for (int i = 0; i < 9; i++) begin
            step();
            chk("wait no write", 32'(wr_en), 32'h0);
        end
        px_valid = 1'b0; nf = 1'b1;
        step();
        nf = 1'b0;
        chk("swap sel", 32'(display_sel), 32'h1);
        chk("swap no overrun", 32'(overrun), 32'h3);

        // Clear of buffer 0, interrupted by reset after address 7.
        for (int i = 0; i < 8; i++) begin
            step();
            chk("clr0 wr_en", 32'(wr_en), 32'h1);
            chk("clr0 addr", 32'(wr_addr), 32'(i));
        end
        rst = 1'b1;
        step();
        chk_reset("midreset");
        rst = 1'b0;
        step();
        chk("restart wr_en", 32'(wr_en), 32'h2);
        chk("restart addr", 32'(wr_addr), 32'h0);

        // Overrun saturation.
        for (int i = 1; i <= 300; i++) begin
            nf = 1'b1;
            step();
            nf = 1'b0;
            step();
            if (i == 3)   chk("sat 3", 32'(overrun), 32'd3);
            if (i == 254) chk("sat 254", 32'(overrun), 32'd254);
            if (i == 255) chk("sat 255", 32'(overrun), 32'd255);
        end
        chk("sat 300", 32'(overrun), 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fb_swap_ctrl.md
# fb_swap_ctrl

Double-buffer controller for the 320x180 RGB565 frame buffers. Sequences each back buffer through clear, render and swap. Owns the single write port into both BRAMs, so clear writes and renderer pixel writes never collide. Selects which buffer the HDMI scan-out path reads, and swaps only on the video timing new-frame pulse so the display never tears.

## Interface
- FB_WIDTH, 320, frame buffer width in pixels
- FB_HEIGHT, 180, frame buffer height in pixels
- FB_DEPTH, FB_WIDTH*FB_HEIGHT (57600), word count per buffer
- CLEAR_COLOR, 16'h0000, RGB565 value written during clear

Ports:
- clk_in  input  1  pixel clock; all logic is in this single domain
- rst_in  input  1  synchronous, active-high reset
- nf_in  input  1  one-cycle new-frame pulse from video_sig_gen
- frame_done_in  input  1  one-cycle pulse: renderer has issued its last pixel for this frame
- px_valid_in  input  1  renderer pixel write request
- px_addr_in  input  16  pixel address, x + FB_WIDTH*y
- px_color_in  input  16  RGB565 pixel
- px_ready_out  output  1  pixel accepted when px_valid_in && px_ready_out
- wr_addr_out  output  16  BRAM port-A address (shared by both buffers)
- wr_data_out  output  16  BRAM port-A data
- wr_en_out  output  2  port-A write enable; bit i = buffer i
- display_sel_out  output  1  buffer being scanned out; back buffer = ~display_sel_out
- frame_start_out  output  1  one-cycle pulse on entry to RENDER; starts the particle stream
- overrun_count_out  output  8  saturating count of missed swap opportunities

## Operation
- States:
  - CLEAR: write CLEAR_COLOR to back buffer, addr 0..FB_DEPTH-1, one word per cycle. Counter reaching FB_DEPTH-1 moves to RENDER.
  - RENDER: px_ready_out=1. Each accepted pixel is written to the back buffer. frame_done_in moves to WAIT_SWAP.
  - WAIT_SWAP: px_ready_out=0. nf_in toggles display_sel_out, resets the clear counter, and moves to CLEAR.
- Write arbitration is exclusive by state: clear writes only in CLEAR; pixel writes only in RENDER. Only the back-buffer bit of wr_en_out is ever asserted.
- An accepted pixel with px_addr_in >= FB_DEPTH is consumed but not written (wr_en_out=0).
- frame_done_in in CLEAR or WAIT_SWAP is ignored.
- A pixel accepted in the same cycle as frame_done_in is written; the state moves to WAIT_SWAP after that cycle.
- nf_in in CLEAR or RENDER increments overrun_count_out, saturating at 255, with no state change.
- nf_in in WAIT_SWAP does not count as an overrun.

## Timing
- Reset values:
  - state=CLEAR, clear counter=0, display_sel_out=0 (back buffer 1)
  - wr_en_out=2'b00, wr_addr_out=0, wr_data_out=0
  - px_ready_out=0, frame_start_out=0, overrun_count_out=0
- px_ready_out is a registered, state-decoded signal. It is independent of px_valid_in in the same cycle.
- Write outputs are registered, so latency is 1 cycle from a clear step or pixel acceptance to wr_en_out/addr/data.
- CLEAR lasts exactly FB_DEPTH cycles of wr_en_out. The first clear write appears the cycle after reset deasserts or the cycle after the swap.
- frame_start_out pulses in the first RENDER cycle, the same cycle px_ready_out first rises.
- display_sel_out toggles the cycle after the accepted nf_in. wr_en_out then targets the new back buffer from that cycle on.
- Reset mid-operation: everything returns to the reset values and the clear restarts from 0 on buffer 1. Writes in flight are abandoned.

## Structure
- Package fb_pkg holds:
  - FB_WIDTH, FB_HEIGHT and FB_DEPTH localparams
  - typedef enum logic [1:0] {CLEAR, RENDER, WAIT_SWAP} fb_state_t
  - typedef logic [15:0] rgb565_t
- Sub-module fb_clear_engine: address counter with start/busy/last signals and registered addr/en outputs. The FSM and write mux stay in fb_swap_ctrl.

## Test plan
- Reset, FB_DEPTH=16:
  - Required: wr_en_out=2'b10 for exactly 16 cycles, addresses 0..15, data 0.
  - Required: then frame_start_out pulses and px_ready_out=1.
- In RENDER, pixel addr 5, color 16'hF800:
  - Required: next cycle wr_en_out=2'b10, wr_addr_out=5, wr_data_out=16'hF800.
  - Required: addr 16 is accepted, but wr_en_out stays 0.
- frame_done_in with a simultaneous valid pixel addr 3:
  - Required: addr 3 is written, then px_ready_out=0.
  - Required: nf_in 10 cycles later gives display_sel_out=1 and a clear of buffer 0 (wr_en_out=2'b01).
- Three nf_in pulses during CLEAR/RENDER:
  - Required: overrun_count_out=3.
  - Required: 300 pulses saturate it at 255.
- rst_in asserted mid-clear (counter=7) on a post-swap frame:
  - Required: display_sel_out=0 and the clear restarts at addr 0 on buffer 1.
- frame_done_in during CLEAR:
  - Required: ignored; RENDER is still entered after the clear and frame_start_out pulses.
